// File: rtl/memory_arbiter.sv
// Unified RAM port arbiter: data-first with a fetch turn, one access at a time.
// Registered RAM strobes, combinational completion path, sticky timeout flag.
module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              arb_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t            state;
  state_t            nxt;
  logic              turn;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_we;

  logic d_req;
  logic pick_d;
  logic pick_i;
  logic in_gnt;
  logic done;
  logic expire;
  logic op_we;

  // turn=1 means fetch has priority on the next contested decision
  assign d_req  = dREN | dWEN;
  assign pick_d = d_req & (~turn | ~iREN);
  assign pick_i = ~pick_d & iREN;
  assign in_gnt = (state != IDLE);
  assign done   = in_gnt & ramready;
  assign expire = in_gnt & ~ramready & (cnt == LAST);

  assign ramaddr  = lat_addr;
  assign ramstore = lat_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt   = state;
    op_we = lat_we;
    unique case (state)
      IDLE: begin
        op_we = pick_d & dWEN;
        if (pick_d) begin
          nxt = DGNT;
        end else if (pick_i) begin
          nxt = IGNT;
        end
      end
      IGNT, DGNT: begin
        if (done | expire) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    iwait = iREN & ~((state == IGNT) & ramready);
    dwait = d_req & ~((state == DGNT) & ramready);
    iload = '0;
    dload = '0;
    if ((state == IGNT) & ramready & iREN) begin
      iload = ramload;
    end
    if ((state == DGNT) & ramready & dREN & ~lat_we) begin
      dload = ramload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      turn     <= 1'b0;
      cnt      <= '0;
      arb_err  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
    end else begin
      cnt    <= in_gnt ? cnt + 1'b1 : '0;
      ramREN <= (nxt == IGNT) | ((nxt == DGNT) & ~op_we);
      ramWEN <= (nxt == DGNT) & op_we;
      if (expire) begin
        arb_err <= 1'b1;
      end
      if (done) begin
        turn <= (state == DGNT);
      end
      // request fields are captured once; later changes never reach RAM
      if ((state == IDLE) & (pick_d | pick_i)) begin
        lat_addr <= pick_d ? daddr : iaddr;
        lat_data <= pick_d ? dstore : '0;
        lat_we   <= op_we;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: table of request mixes with an access scoreboard,
// plus hand sequences for reset, alternation, timeout, drop and latching.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iren = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        iwait;
  logic        dren = 1'b0;
  logic        dwen = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load = '0;
  logic        ram_ready = 1'b0;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr),
    .ramstore(ram_store), .ramload(ram_load), .ramready(ram_ready),
    .arb_err(arb_err)
  );

  typedef struct {
    logic        i_en;
    logic [31:0] ia;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] da;
    logic [31:0] ds;
    logic        d_first;
  } vec_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
  } acc_t;

  acc_t sbq[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ram_ren | ram_wen) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s no strobe within 40 cycles", name);
    end
  endtask

  function automatic acc_t mk(input logic port, input logic we,
                              input logic [31:0] addr,
                              input logic [31:0] store);
    acc_t a;
    a.port  = port;
    a.we    = we;
    a.addr  = addr;
    a.store = we ? store : 32'h0;
    a.rdata = $urandom;
    return a;
  endfunction

  task automatic serve(input acc_t a, input bit drop);
    bit ok;
    wait_strobe("grant", ok);
    if (!ok) return;
    check("ramREN", 32'(ram_ren), 32'(!a.we));
    check("ramWEN", 32'(ram_wen), 32'(a.we));
    check("ramaddr", ram_addr, a.addr);
    if (a.we) check("ramstore", ram_store, a.store);
    ram_load  = a.rdata;
    ram_ready = 1'b1;
    #1;
    if (a.port) begin
      check("dwait_done", 32'(dwait), 32'h0);
      if (!a.we) check("dload", dload, a.rdata);
    end else begin
      check("iwait_done", 32'(iwait), 32'h0);
      check("iload", iload, a.rdata);
    end
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    ram_load  = '0;
    if (drop) begin
      if (a.port) begin
        dren = 1'b0;
        dwen = 1'b0;
      end else begin
        iren = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    bit ok;
    acc_t ea;
    acc_t eb;

    vecs[0] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b1};
    vecs[2] = '{1'b1, 32'h84, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1'b1};
    vecs[4] = '{1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 32'h8C, 1'b0, 1'b1, 32'h308, 32'h000055AA, 1'b1};

    // reset with a pending fetch
    iren  = 1'b1;
    iaddr = 32'h40;
    repeat (3) @(negedge clk);
    check("rst_iwait", 32'(iwait), 32'h1);
    check("rst_dwait", 32'(dwait), 32'h0);
    check("rst_ramREN", 32'(ram_ren), 32'h0);
    check("rst_ramWEN", 32'(ram_wen), 32'h0);
    check("rst_ramaddr", ram_addr, 32'h0);
    check("rst_ramstore", ram_store, 32'h0);
    check("rst_iload", iload, 32'h0);
    check("rst_arb_err", 32'(arb_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_ramREN", 32'(ram_ren), 32'h1);
    check("t1_ramaddr", ram_addr, 32'h40);
    ram_load  = 32'hDEADBEEF;
    ram_ready = 1'b1;
    #1;
    check("t1_iload", iload, 32'hDEADBEEF);
    check("t1_iwait", 32'(iwait), 32'h0);
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    iren      = 1'b0;

    // table of request mixes, accesses checked through the scoreboard
    for (int v = 0; v < 6; v++) begin
      ea = mk(1'b1, vecs[v].d_wr, vecs[v].da, vecs[v].ds);
      eb = mk(1'b0, 1'b0, vecs[v].ia, 32'h0);
      if ((vecs[v].d_rd | vecs[v].d_wr) && vecs[v].i_en) begin
        if (vecs[v].d_first) begin
          sbq.push_back(ea);
          sbq.push_back(eb);
        end else begin
          sbq.push_back(eb);
          sbq.push_back(ea);
        end
      end else if (vecs[v].i_en) begin
        sbq.push_back(eb);
      end else begin
        sbq.push_back(ea);
      end
      @(negedge clk);
      iren   = vecs[v].i_en;
      iaddr  = vecs[v].ia;
      dren   = vecs[v].d_rd;
      dwen   = vecs[v].d_wr;
      daddr  = vecs[v].da;
      dstore = vecs[v].ds;
      while (sbq.size() > 0) serve(sbq.pop_front(), 1'b1);
    end

    // both held continuously: D,I,D,I
    @(negedge clk);
    iren  = 1'b1;
    iaddr = 32'h90;
    dren  = 1'b1;
    daddr = 32'h110;
    serve(mk(1'b1, 1'b0, 32'h110, 32'h0), 1'b0);
    serve(mk(1'b0, 1'b0, 32'h90, 32'h0), 1'b0);
    serve(mk(1'b1, 1'b0, 32'h110, 32'h0), 1'b0);
    serve(mk(1'b0, 1'b0, 32'h90, 32'h0), 1'b0);
    iren = 1'b0;
    dren = 1'b0;

    // store fields latched at grant
    @(negedge clk);
    dwen   = 1'b1;
    daddr  = 32'h200;
    dstore = 32'h12345678;
    wait_strobe("t3", ok);
    check("t3_ramWEN", 32'(ram_wen), 32'h1);
    check("t3_ramREN", 32'(ram_ren), 32'h0);
    dstore = 32'hFFFF0000;
    daddr  = 32'h999;
    repeat (2) @(negedge clk);
    check("t3_ramstore", ram_store, 32'h12345678);
    check("t3_ramaddr", ram_addr, 32'h200);
    check("t3_dwait_hi", 32'(dwait), 32'h1);
    ram_ready = 1'b1;
    #1;
    check("t3_dwait_lo", 32'(dwait), 32'h0);
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    dwen      = 1'b0;

    // timeout abort and re-grant
    @(negedge clk);
    dren  = 1'b1;
    daddr = 32'h400;
    wait_strobe("t4", ok);
    check("t4_err_pre", 32'(arb_err), 32'h0);
    n = 0;
    while (ram_ren && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t4_hold_cycles", 32'(n), 32'd16);
    check("t4_arb_err", 32'(arb_err), 32'h1);
    check("t4_ramREN_off", 32'(ram_ren), 32'h0);
    check("t4_dwait", 32'(dwait), 32'h1);
    serve(mk(1'b1, 1'b0, 32'h400, 32'h0), 1'b1);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(arb_err), 32'h1);

    // read request dropped mid-grant
    dren  = 1'b1;
    daddr = 32'h500;
    wait_strobe("t5", ok);
    dren = 1'b0;
    #1;
    check("t5_dwait_drop", 32'(dwait), 32'h0);
    @(negedge clk);
    check("t5_still_reading", 32'(ram_ren), 32'h1);
    ram_ready = 1'b1;
    @(posedge clk);
    #1;
    ram_ready = 1'b0;
    @(negedge clk);
    check("t5_released", 32'(ram_ren), 32'h0);
    iren  = 1'b1;
    iaddr = 32'h700;
    serve(mk(1'b0, 1'b0, 32'h700, 32'h0), 1'b1);

    // async reset during a fetch grant
    @(negedge clk);
    iren  = 1'b1;
    iaddr = 32'h600;
    wait_strobe("t6", ok);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ramREN_async", 32'(ram_ren), 32'h0);
    check("t6_iwait_rst", 32'(iwait), 32'h1);
    check("t6_err_cleared", 32'(arb_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    serve(mk(1'b0, 1'b0, 32'h600, 32'h0), 1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
